// File: rtl/batch_conv_seq_if.sv
// batch_conv_seq_if: data-memory port and converter-core handshake used by batch_conv_seq.
interface batch_conv_seq_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rd_data;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;
  logic              core_start;
  logic [15:0]       core_op;
  logic              core_ack;
  logic [15:0]       core_result;
  modport master (
    output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, core_start, core_op,
    input  mem_rd_data, core_ack, core_result
  );
  modport slave (
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, core_start, core_op,
    output mem_rd_data, core_ack, core_result
  );
endinterface

// File: rtl/batch_conv_seq.sv
// batch_conv_seq: walks a batch of fixed(8.8) operands through a float16 converter core and writes results back.
// Define BATCH_CONV_SEQ_TIMEOUT_EN to add a watchdog on the converter wait (limit TIMEOUT_CYC).
module batch_conv_seq #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        job_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        jobs_done,
  batch_conv_seq_if.master  bus
);
  typedef enum logic [3:0] {IDLE, RD_LO, RD_HI, CAP, START1, START2, WAIT, WR_LO, WR_HI, FIN, ERR} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] a_q, a_d, addr_c;
  logic [7:0]        cnt_q, cnt_d, jobs_done_q, jobs_done_d, lo_q, lo_d, wd_c;
  logic [15:0]       op_q, op_d, res_q, res_d;
  logic              armed_q, armed_d, rd_c, wr_c, start_c, ack_ok, tmo_hit;
`ifdef BATCH_CONV_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  always_comb tmo_d = (state_q == WAIT) ? tmo_q + TW'(1) : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) tmo_q <= '0;
    else tmo_q <= tmo_d;
  assign tmo_hit = (state_q == WAIT) && (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign err     = state_q == ERR;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo_hit    = 1'b0;
  assign err        = 1'b0;
`endif
  // A high ack only counts after it has been seen low since this job's START1.
  assign ack_ok = bus.core_ack & armed_q;
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    cnt_d       = cnt_q;
    jobs_done_d = jobs_done_q;
    lo_d        = lo_q;
    op_d        = op_q;
    res_d       = res_q;
    armed_d     = armed_q | ((state_q inside {START1, START2, WAIT}) & ~bus.core_ack);
    addr_c      = '0;
    rd_c        = 1'b0;
    wr_c        = 1'b0;
    wd_c        = '0;
    start_c     = 1'b0;
    case (state_q)
      IDLE, FIN, ERR: if (go) begin
        a_d         = base_addr;
        cnt_d       = job_count;
        jobs_done_d = '0;
        state_d     = (job_count == 8'd0) ? FIN : RD_LO;
      end
      RD_LO: begin
        addr_c  = a_q;
        rd_c    = 1'b1;
        state_d = RD_HI;
      end
      RD_HI: begin
        addr_c  = a_q + ADDR_W'(1);
        rd_c    = 1'b1;
        lo_d    = bus.mem_rd_data;
        state_d = CAP;
      end
      CAP: begin
        op_d    = {bus.mem_rd_data, lo_q};
        armed_d = 1'b0;
        state_d = START1;
      end
      START1: begin
        start_c = 1'b1;
        state_d = START2;
      end
      START2: begin
        start_c = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        res_d   = ack_ok ? bus.core_result : res_q;
        state_d = ack_ok ? WR_LO : tmo_hit ? ERR : WAIT;
      end
      WR_LO: begin
        addr_c  = a_q + ADDR_W'(2);
        wr_c    = 1'b1;
        wd_c    = res_q[7:0];
        state_d = WR_HI;
      end
      WR_HI: begin
        addr_c      = a_q + ADDR_W'(3);
        wr_c        = 1'b1;
        wd_c        = res_q[15:8];
        jobs_done_d = jobs_done_q + 8'd1;
        a_d         = a_q + ADDR_W'(4);
        state_d     = (jobs_done_d == cnt_q) ? FIN : RD_LO;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      cnt_q       <= '0;
      jobs_done_q <= '0;
      lo_q        <= '0;
      op_q        <= '0;
      res_q       <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      cnt_q       <= cnt_d;
      jobs_done_q <= jobs_done_d;
      lo_q        <= lo_d;
      op_q        <= op_d;
      res_q       <= res_d;
      armed_q     <= armed_d;
    end
  assign busy            = !(state_q inside {IDLE, FIN, ERR});
  assign done            = state_q == FIN;
  assign jobs_done       = jobs_done_q;
  assign bus.mem_addr    = addr_c;
  assign bus.mem_rd_en   = rd_c;
  assign bus.mem_wr_en   = wr_c;
  assign bus.mem_wr_data = wd_c;
  assign bus.core_start  = start_c;
  assign bus.core_op     = op_q;
endmodule

// File: tb/tb_batch_conv_seq.sv
// tb_batch_conv_seq: vector table plus reset/stale-ack/watchdog sequences against a memory and converter model,
// with a scoreboard of expected reads, core operands and writes.
module tb_batch_conv_seq;
  logic        clk = 1'b0, reset = 1'b1, go = 1'b0;
  logic [7:0]  base_addr = '0, job_count = '0;
  logic        busy, done, err;
  logic [7:0]  jobs_done;
  batch_conv_seq_if #(.ADDR_W(8)) bus ();
  batch_conv_seq #(.ADDR_W(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .go(go), .base_addr(base_addr), .job_count(job_count),
    .busy(busy), .done(done), .err(err), .jobs_done(jobs_done), .bus(bus)
  );
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] conv(input logic [15:0] op);
    case (op)
      16'h0001: conv = 16'h1C00;
      16'h0030: conv = 16'h3200;
      16'hFFFF: conv = 16'h9C00;
      16'h7FFF: conv = 16'h5800;
      default:  conv = op ^ 16'h5A5A;
    endcase
  endfunction

  logic [7:0] mem [256];
  logic       ld_en = 1'b0;
  logic [7:0] ld_a = '0, ld_d = '0, rd_m = '0;
  assign bus.mem_rd_data = rd_m;
  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
    rd_m <= mem[bus.mem_addr];
  end

  // Converter model: after each start, ack stays high for `hold` cycles with a poisoned result,
  // then low for dly+1 cycles, then high with the real result.
  int          hold = 0, dly = 0, t = 0;
  bit          never_ack = 1'b0, pending = 1'b0;
  logic        ack_m = 1'b0, start_prev = 1'b0;
  logic [15:0] res_m = '0, res_pend = '0;
  assign bus.core_ack    = ack_m;
  assign bus.core_result = res_m;
  always @(posedge clk) begin
    start_prev <= bus.core_start;
    if (bus.core_start && !start_prev) begin
      pending  <= 1'b1;
      t        <= 0;
      ack_m    <= hold != 0;
      res_m    <= 16'hDEAD;
      res_pend <= conv(bus.core_op);
    end else if (pending && !never_ack) begin
      t     <= t + 1;
      ack_m <= (t + 1 < hold) || (t + 1 > hold + dly);
      if (t + 1 > hold + dly) begin
        res_m   <= res_pend;
        pending <= 1'b0;
      end
    end
  end

  logic [15:0] wr_q[$], op_q[$];
  logic [7:0]  rd_q[$];
  int          cs_total = 0;
  logic        cs_prev = 1'b0;
  always @(negedge clk) begin
    cs_prev <= bus.core_start;
    if (bus.core_start) cs_total++;
    if (bus.mem_rd_en || bus.mem_wr_en) chk("rd_wr_exclusive", {31'd0, bus.mem_rd_en & bus.mem_wr_en}, 0);
    if (bus.mem_wr_en) begin
      if (wr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected: addr %0h data %0h, expected no write", bus.mem_addr, bus.mem_wr_data);
      end else chk("wr", {bus.mem_addr, bus.mem_wr_data}, wr_q.pop_front());
    end
    if (bus.mem_rd_en) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: addr %0h, expected no read", bus.mem_addr);
      end else chk("rd_addr", bus.mem_addr, rd_q.pop_front());
    end
    if (bus.core_start && !cs_prev) begin
      if (op_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL start_unexpected: op %0h, expected no start", bus.core_op);
      end else chk("core_op", bus.core_op, op_q.pop_front());
    end
  end

  typedef struct {
    logic [7:0]       base, cnt;
    logic [2:0][15:0] ops;
    int               hold, dly;
    bit               poke;
  } vec_t;

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld_a  = a;
    ld_d  = d;
    ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Preload operands and queue expectations for jobs [0, n_full) fully and [n_full, n_rd) up to the core start.
  task automatic prep(input vec_t v, input int n_full, input int n_rd);
    logic [7:0]  a;
    logic [15:0] r;
    for (int i = 0; i < n_rd; i++) begin
      a = v.base + 8'(4 * i);
      load(a, v.ops[i][7:0]);
      load(a + 8'd1, v.ops[i][15:8]);
      rd_q.push_back(a);
      rd_q.push_back(a + 8'd1);
      op_q.push_back(v.ops[i]);
      r = conv(v.ops[i]);
      if (i < n_full) begin
        wr_q.push_back({a + 8'd2, r[7:0]});
        wr_q.push_back({a + 8'd3, r[15:8]});
      end
    end
    hold = v.hold;
    dly  = v.dly;
  endtask

  task automatic run(input vec_t v);
    int k, cs0;
    prep(v, int'(v.cnt), int'(v.cnt));
    cs0       = cs_total;
    base_addr = v.base;
    job_count = v.cnt;
    go        = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    chk("busy_after_go", {31'd0, busy}, {31'd0, v.cnt != 0});
    k = 0;
    while (!done && !err && k < 2000) begin
      go = v.poke && k == 2;
      base_addr = go ? ~v.base : v.base;
      @(posedge clk); #1;
      k++;
    end
    go = 1'b0;
    chk("latency", k, v.cnt * (8 + v.hold + v.dly));
    chk("done", {31'd0, done}, 1);
    chk("busy_end", {31'd0, busy}, 0);
    chk("err_end", {31'd0, err}, 0);
    chk("jobs_done", jobs_done, v.cnt);
    chk("start_cycles", cs_total - cs0, 2 * v.cnt);
    chk("queues_drained", wr_q.size() + rd_q.size() + op_q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_status"}, {busy, done, err, jobs_done}, 0);
    chk({tag, "_mem"}, {bus.mem_addr, bus.mem_rd_en, bus.mem_wr_en, bus.mem_wr_data}, 0);
    chk({tag, "_core"}, {bus.core_start, bus.core_op}, 0);
  endtask

  vec_t vt[5];
  vec_t mv;
  int   k;
  initial begin
    vt[0] = '{8'h00, 8'd1, {16'h0000, 16'h0000, 16'h0001}, 0, 2, 1'b0};
    vt[1] = '{8'h10, 8'd3, {16'h7FFF, 16'hFFFF, 16'h0030}, 0, 0, 1'b0};
    vt[2] = '{8'h00, 8'd0, {16'h0000, 16'h0000, 16'h0000}, 0, 0, 1'b0};
    vt[3] = '{8'hF8, 8'd3, {16'h0100, 16'h8000, 16'h1234}, 0, 5, 1'b1};
    vt[4] = '{8'h40, 8'd2, {16'h0000, 16'h0030, 16'h0001}, 4, 1, 1'b0};
    #1 reset = 1'b0;
    #11;
    chk_zero("reset_init");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    foreach (vt[i]) run(vt[i]);
    repeat (3) begin @(posedge clk); #1; end
    chk("done_hold", {31'd0, done}, 1);

    mv = '{8'h80, 8'd2, {16'h0000, 16'h7FFF, 16'h0030}, 0, 20, 1'b0};
    load(8'h86, 8'hAA);
    load(8'h87, 8'hBB);
    prep(mv, 1, 2);
    base_addr = mv.base;
    job_count = mv.cnt;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    k = 0;
    while (jobs_done != 8'd1 && k < 200) begin @(posedge clk); #1; k++; end
    chk("mid_job1_reached", jobs_done, 1);
    repeat (7) begin @(posedge clk); #1; end
    chk("mid_in_wait", {busy, bus.core_start, bus.mem_rd_en, bus.mem_wr_en}, 4'b1000);
    #2 reset = 1'b0;
    #1;
    chk_zero("reset_mid");
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    repeat (30) begin @(posedge clk); #1; end
    chk("mid_res_lo_kept", mem[8'h86], 8'hAA);
    chk("mid_res_hi_kept", mem[8'h87], 8'hBB);
    chk("mid_idle", {busy, done, jobs_done}, 0);
    mv.dly = 1;
    run(mv);

`ifdef BATCH_CONV_SEQ_TIMEOUT_EN
    mv = '{8'h20, 8'd2, {16'h0000, 16'h0030, 16'h0001}, 0, 0, 1'b0};
    never_ack = 1'b1;
    prep(mv, 0, 1);
    base_addr = mv.base;
    job_count = mv.cnt;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    k = 0;
    while (!err && k < 200) begin @(posedge clk); #1; k++; end
    chk("tmo_latency", k, 21);
    chk("tmo_flags", {busy, done, err, jobs_done}, 11'b001_0000_0000);
    never_ack = 1'b0;
    mv.cnt = 8'd1;
    run(mv);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected summary");
    $fatal(1);
  end
endmodule

// File: doc/batch_conv_seq.md
BATCH_CONV_SEQ -- requirements
Module: batch_conv_seq

Interface
REQ-001 Parameter ADDR_W, default 8, data-memory address width; all address arithmetic is modulo 2^ADDR_W.
REQ-002 Parameter TIMEOUT_CYC, default 1024, watchdog limit in cycles; used only when BATCH_CONV_SEQ_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 go  input  1  request to start a batch.
REQ-006 base_addr  input  ADDR_W  address of job 0 operand low byte.
REQ-007 job_count  input  8  number of jobs in the batch, 0..255.
REQ-008 busy  output  1  high while a batch is in progress.
REQ-009 done  output  1  batch complete; a level, not a pulse.
REQ-010 err  output  1  watchdog expired.
REQ-011 jobs_done  output  8  number of jobs fully written back.
REQ-012 mem_addr  output  ADDR_W  data-memory address.
REQ-013 mem_rd_en  output  1  memory read strobe.
REQ-014 mem_rd_data  input  8  read data, valid one cycle after mem_rd_en.
REQ-015 mem_wr_en  output  1  memory write strobe.
REQ-016 mem_wr_data  output  8  memory write data.
REQ-017 core_start  output  1  start request to the fixed(8.8)-to-float16 converter core.
REQ-018 core_op  output  16  converter operand.
REQ-019 core_ack  input  1  converter done level.
REQ-020 core_result  input  16  converter float16 result.

Function
REQ-021 Job i memory layout: operand lo at A=base_addr+4i, operand hi at A+1, result lo at A+2, result hi at A+3.
REQ-022 States: IDLE, RD_LO, RD_HI, CAP, START1, START2, WAIT, WR_LO, WR_HI, FIN, ERR.
REQ-023 go is sampled only in IDLE, FIN or ERR; go in any other state is ignored.
REQ-024 On an accepted go, the block latches base_addr and job_count, clears jobs_done, done and err, and sets busy.
REQ-025 After an accepted go with job_count=0, the next state is FIN, done rises one cycle after go, and no memory or core access occurs.
REQ-026 RD_LO: mem_addr=A, mem_rd_en=1; RD_HI: mem_addr=A+1, mem_rd_en=1, operand lo captured; CAP: operand hi captured and core_op updated.
REQ-027 START1 and START2 each drive core_start=1, so core_start is high for exactly 2 cycles; core_op is held stable from CAP until the WR_LO exit.
REQ-028 An ack-armed flag clears on START1 entry and sets once core_ack is sampled low; WAIT exits only on core_ack=1 with the flag set, so a stale high ack is ignored.
REQ-029 core_result is captured in the cycle the qualified ack is seen.
REQ-030 WR_LO: mem_addr=A+2, mem_wr_data=result[7:0], mem_wr_en=1; WR_HI: mem_addr=A+3, mem_wr_data=result[15:8], mem_wr_en=1, and jobs_done increments.
REQ-031 After WR_HI, the next state is RD_LO for job i+1 if jobs remain, else FIN.
REQ-032 In FIN: busy=0, done=1, held until the next accepted go or reset.
REQ-033 mem_rd_en and mem_wr_en are never high in the same cycle; both are 0 outside the states named above.
REQ-034 Per-job latency is 8 cycles plus the WAIT dwell time.
REQ-035 Address wrap past 2^ADDR_W-1 continues at 0 with no error.

Reset
REQ-036 When reset=0, the block asynchronously enters IDLE and sets busy, done, err, jobs_done, mem_*, core_start and core_op to 0.
REQ-037 Reset mid-batch abandons the batch immediately; any write not already strobed does not occur.
REQ-038 After reset release, the block waits in IDLE for go.

Configuration
REQ-039 With BATCH_CONV_SEQ_TIMEOUT_EN defined, a counter clears on WAIT entry; if it reaches TIMEOUT_CYC in WAIT, the block enters ERR with err=1, busy=0, done=0, and no write for that job.
REQ-040 Without BATCH_CONV_SEQ_TIMEOUT_EN, WAIT never times out, err is tied 0, ERR is unreachable, and no counter is built.

Verification
REQ-041 base_addr=0, job_count=1, mem[0]=0x01, mem[1]=0x00, core returns 0x1C00 -> core_op=0x0001, core_start high 2 cycles, mem[2]=0x00, mem[3]=0x1C, done=1, jobs_done=1.
REQ-042 base_addr=0x10, job_count=3, operands 0x0030, 0xFFFF, 0x7FFF -> results written at 0x12/13, 0x16/17, 0x1A/1B in job order, with done after the third WR_HI.
REQ-043 job_count=0 -> done=1 one cycle after go, with zero mem_rd_en, mem_wr_en and core_start activity.
REQ-044 core_ack held high from the previous job into START1 -> no exit from WAIT until ack goes low and then high again.
REQ-045 reset pulled low in WAIT of job 1 of 2 -> all outputs 0 immediately, mem[base+6..7] unchanged, and a new go restarts at job 0.
REQ-046 With TIMEOUT_EN and TIMEOUT_CYC=16, core_ack never rises -> err=1 after 16 WAIT cycles, with no write to A+2 or A+3.
